// File: rtl/countdown_timer_ctrl.sv
// ============================================================================
//  Module   : countdown_timer_ctrl
//  Brief    : Seconds countdown controller with internal tick prescaler and
//             start/pause/clear sequencing. Optional macro TIMER_AUTORELOAD_EN
//             turns it into a periodic timer that reloads on reaching zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_timer_ctrl #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1,
   parameter int SEC_W   = 8
) (
   input  logic             clk_100mhz,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic [SEC_W-1:0] load_val,
   output logic [SEC_W-1:0] sec_left,
   output logic             tick,
   output logic             running,
   output logic             done,
   output logic [1:0]       state
);

   localparam int c_div     = CLK_HZ / TICK_HZ;
   localparam int c_presc_w = (c_div > 1) ? $clog2(c_div) : 1;
   localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(c_div - 1);
   localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);
   localparam logic [SEC_W-1:0]     c_sec_one    = SEC_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 r_state,    w_next_state;
   logic [c_presc_w-1:0]   r_presc,    w_next_presc;
   logic [SEC_W-1:0]       r_sec_left, w_next_sec;
   logic                   r_done,     w_next_done;
   logic                   w_tick;

   // Tick is suppressed by clear so an aborted period never reaches downstream logic.
   assign w_tick = (r_state == S_RUN) && (r_presc == c_presc_last) && !clear;

   always_ff @(posedge clk_100mhz or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_presc    <= '0;
         r_sec_left <= '0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_presc    <= w_next_presc;
         r_sec_left <= w_next_sec;
         r_done     <= w_next_done;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_presc = r_presc;
      w_next_sec   = r_sec_left;
      w_next_done  = 1'b0;

      if (clear) begin
         w_next_state = S_IDLE;
         w_next_presc = '0;
         w_next_sec   = '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               w_next_presc = '0;
               if (!pause && start) begin
                  w_next_sec = load_val;
                  if (load_val != '0) begin
                     w_next_state = S_RUN;
                  end else begin
                     w_next_state = S_DONE;
                     w_next_done  = 1'b1;
                  end
               end
            end
            S_RUN: begin
               w_next_presc = w_tick ? '0 : (r_presc + c_presc_one);
               if (pause) w_next_state = S_PAUSE;
               // Reaching zero overrides a simultaneous pause request.
               if (w_tick) begin
                  if (r_sec_left > c_sec_one) begin
                     w_next_sec = r_sec_left - c_sec_one;
                  end else begin
                     w_next_done = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                     w_next_sec = load_val;
                     if (load_val == '0) w_next_state = S_DONE;
`else
                     w_next_sec   = '0;
                     w_next_state = S_DONE;
`endif
                  end
               end
            end
            S_PAUSE: begin
               if (!pause && start) w_next_state = S_RUN;
            end
            default: begin
               w_next_state = S_IDLE;
            end
         endcase
      end
   end

   assign sec_left = r_sec_left;
   assign tick     = w_tick;
   assign running  = (r_state == S_RUN);
   assign done     = r_done;
   assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_ctrl.sv
// ============================================================================
//  Module   : tb_countdown_timer_ctrl
//  Brief    : Directed self-checking bench for countdown_timer_ctrl with
//             DIV=10; expectations follow TIMER_AUTORELOAD_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_timer_ctrl;

   logic       clk_100mhz = 1'b0;
   logic       reset      = 1'b1;
   logic       start      = 1'b0;
   logic       pause      = 1'b0;
   logic       clear      = 1'b0;
   logic [7:0] load_val   = 8'd0;
   logic [7:0] sec_left;
   logic       tick;
   logic       running;
   logic       done;
   logic [1:0] state;

   int errors = 0;
   int checks = 0;

   countdown_timer_ctrl #(
      .CLK_HZ  (10),
      .TICK_HZ (1),
      .SEC_W   (8)
   ) dut (
      .clk_100mhz (clk_100mhz),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .clear      (clear),
      .load_val   (load_val),
      .sec_left   (sec_left),
      .tick       (tick),
      .running    (running),
      .done       (done),
      .state      (state)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   // Observation point: 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic go_idle();
      start = 1'b0;
      pause = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({state, sec_left, tick, done, running} !== 13'd0) begin
         errors++;
         $display("FAIL reset_initial: got st=%0d sec=%0d tick=%b done=%b run=%b, want all 0",
                  state, sec_left, tick, done, running);
      end
      step();
      reset = 1'b0;
      load_val = 8'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (15) step();
      checks++;
      if (running !== 1'b1 || sec_left !== 8'd6) begin
         errors++;
         $display("FAIL reset_precount: got run=%b sec=%0d, want run=1 sec=6", running, sec_left);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({state, sec_left, tick, done, running} !== 13'd0) begin
         errors++;
         $display("FAIL reset_midcount: got st=%0d sec=%0d tick=%b done=%b run=%b, want all 0",
                  state, sec_left, tick, done, running);
      end
      step();
      reset = 1'b0;
   endtask

   // load 3: ticks consumed at edges 10/20/30 after the start edge, done seen after edge 30.
   task automatic test_basic();
      int ntick = 0;
      int tick_at[3] = '{0, 0, 0};
      int done_at = -1;
      int ndone = 0;
      logic sec_bad = 1'b0;
      go_idle();
      load_val = 8'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 2'd1 || sec_left !== 8'd3 || running !== 1'b1) begin
         errors++;
         $display("FAIL basic_start: got st=%0d sec=%0d run=%b, want st=1 sec=3 run=1",
                  state, sec_left, running);
      end
      for (int k = 1; k <= 40; k++) begin
         if (tick === 1'b1) begin
            if (ntick < 3) tick_at[ntick] = k;
            ntick++;
         end
         step();
         if (done === 1'b1) begin
            ndone++;
            if (done_at < 0) done_at = k;
         end
         if ((k == 9 && sec_left !== 8'd3) || (k == 10 && sec_left !== 8'd2) ||
             (k == 20 && sec_left !== 8'd1) || (k == 30 && sec_left !== 8'd0))
            sec_bad = 1'b1;
      end
      checks++;
      if (ntick != 3 || tick_at[0] != 10 || tick_at[1] != 20 || tick_at[2] != 30) begin
         errors++;
         $display("FAIL basic_ticks: got n=%0d at %0d/%0d/%0d, want n=3 at 10/20/30",
                  ntick, tick_at[0], tick_at[1], tick_at[2]);
      end
      checks++;
      if (sec_bad) begin
         errors++;
         $display("FAIL basic_sec_seq: sec_left sequence deviated from 3,2,1,0");
      end
`ifndef TIMER_AUTORELOAD_EN
      checks++;
      if (done_at != 30 || ndone != 1 || state !== 2'd3 || sec_left !== 8'd0) begin
         errors++;
         $display("FAIL basic_done: got at=%0d n=%0d st=%0d sec=%0d, want at=30 n=1 st=3 sec=0",
                  done_at, ndone, state, sec_left);
      end
`else
      checks++;
      if (done_at != 30 || ndone != 1 || state !== 2'd1) begin
         errors++;
         $display("FAIL basic_done: got at=%0d n=%0d st=%0d, want at=30 n=1 st=1",
                  done_at, ndone, state);
      end
`endif
   endtask

   // Pause sampled at edge 14 (prescaler held at 4), resume at R: ticks at R+6, done at R+36.
   task automatic test_pause();
      logic hold_bad = 1'b0;
      int first_tick = -1;
      int done_at = -1;
      go_idle();
      load_val = 8'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (13) step();
      pause = 1'b1;
      step();
      checks++;
      if (state !== 2'd2 || sec_left !== 8'd4 || running !== 1'b0) begin
         errors++;
         $display("FAIL pause_enter: got st=%0d sec=%0d run=%b, want st=2 sec=4 run=0",
                  state, sec_left, running);
      end
      repeat (24) begin
         if (state !== 2'd2 || sec_left !== 8'd4 || tick !== 1'b0) hold_bad = 1'b1;
         step();
      end
      checks++;
      if (hold_bad) begin
         errors++;
         $display("FAIL pause_hold: state/sec_left/tick moved during pause (want st=2 sec=4 tick=0)");
      end
      pause = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (tick === 1'b1 && first_tick < 0) first_tick = k;
         step();
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      checks++;
      if (first_tick != 6) begin
         errors++;
         $display("FAIL pause_resume_tick: got edge %0d, want 6", first_tick);
      end
      checks++;
      if (done_at != 36) begin
         errors++;
         $display("FAIL pause_done: got edge %0d after resume, want 36", done_at);
      end
   endtask

   task automatic test_clear_on_tick();
      logic quiet_bad = 1'b0;
      go_idle();
      load_val = 8'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      checks++;
      if (tick !== 1'b1 || sec_left !== 8'd2) begin
         errors++;
         $display("FAIL clear_pre: got tick=%b sec=%0d, want tick=1 sec=2", tick, sec_left);
      end
      clear = 1'b1;
      #1;
      checks++;
      if (tick !== 1'b0) begin
         errors++;
         $display("FAIL clear_tick_mask: got tick=%b, want 0", tick);
      end
      step();
      clear = 1'b0;
      repeat (3) begin
         if (state !== 2'd0 || sec_left !== 8'd0 || done !== 1'b0 || tick !== 1'b0) quiet_bad = 1'b1;
         step();
      end
      checks++;
      if (quiet_bad) begin
         errors++;
         $display("FAIL clear_result: got st=%0d sec=%0d done=%b, want st=0 sec=0 done=0",
                  state, sec_left, done);
      end
   endtask

   task automatic test_zero_and_one();
      int ntick = 0;
      int done_at = -1;
      go_idle();
      load_val = 8'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (state !== 2'd3 || done !== 1'b1 || sec_left !== 8'd0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL zero_load: got st=%0d done=%b sec=%0d tick=%b, want st=3 done=1 sec=0 tick=0",
                  state, done, sec_left, tick);
      end
      step();
      checks++;
      if (state !== 2'd3 || done !== 1'b0) begin
         errors++;
         $display("FAIL zero_pulse: got st=%0d done=%b, want st=3 done=0", state, done);
      end
      load_val = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (tick === 1'b1) ntick++;
         step();
         if (done === 1'b1 && done_at < 0) done_at = k;
      end
      checks++;
      if (ntick != 1 || done_at != 10) begin
         errors++;
         $display("FAIL one_load: got ticks=%0d done_at=%0d, want ticks=1 done_at=10",
                  ntick, done_at);
      end
   endtask

   task automatic test_priority();
      go_idle();
      load_val = 8'd4;
      pause = 1'b1;
      start = 1'b1;
      step();
      checks++;
      if (state !== 2'd0) begin
         errors++;
         $display("FAIL prio_pause_over_start: got st=%0d, want 0", state);
      end
      pause = 1'b0;
      clear = 1'b1;
      step();
      checks++;
      if (state !== 2'd0 || sec_left !== 8'd0) begin
         errors++;
         $display("FAIL prio_clear_over_start: got st=%0d sec=%0d, want st=0 sec=0", state, sec_left);
      end
      clear = 1'b0;
      repeat (25) step();
      checks++;
      if (state !== 2'd1 || sec_left !== 8'd2) begin
         errors++;
         $display("FAIL no_retrigger: got st=%0d sec=%0d, want st=1 sec=2", state, sec_left);
      end
      start = 1'b0;
   endtask

`ifdef TIMER_AUTORELOAD_EN
   task automatic test_autoreload();
      int ndone = 0;
      int done_at = -1;
      logic run_bad = 1'b0;
      logic sec_bad = 1'b0;
      go_idle();
      load_val = 8'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         step();
         if (done === 1'b1) begin
            ndone++;
            if (done_at < 0) done_at = k;
         end
         if (running !== 1'b1) run_bad = 1'b1;
         if ((k == 10 && sec_left !== 8'd1) || (k == 20 && sec_left !== 8'd2) ||
             (k == 30 && sec_left !== 8'd1) || (k == 40 && sec_left !== 8'd2))
            sec_bad = 1'b1;
      end
      checks++;
      if (ndone != 3 || done_at != 20) begin
         errors++;
         $display("FAIL autoreload_done: got n=%0d first=%0d, want n=3 first=20", ndone, done_at);
      end
      checks++;
      if (run_bad || sec_bad) begin
         errors++;
         $display("FAIL autoreload_run: run_drop=%b sec_dev=%b, want both 0", run_bad, sec_bad);
      end
   endtask
`else
   task automatic test_done_hold();
      logic hold_bad = 1'b0;
      go_idle();
      load_val = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      checks++;
      if (state !== 2'd3 || done !== 1'b1) begin
         errors++;
         $display("FAIL done_enter: got st=%0d done=%b, want st=3 done=1", state, done);
      end
      repeat (15) begin
         step();
         if (state !== 2'd3 || sec_left !== 8'd0 || running !== 1'b0 ||
             tick !== 1'b0 || done !== 1'b0)
            hold_bad = 1'b1;
      end
      checks++;
      if (hold_bad) begin
         errors++;
         $display("FAIL done_hold: DONE not held quietly (want st=3 sec=0 run=0 tick=0 done=0)");
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_clear_on_tick();
      test_zero_and_one();
      test_priority();
`ifdef TIMER_AUTORELOAD_EN
      test_autoreload();
`else
      test_done_hold();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
